// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multi-cycle multiply/divide sequencer for the E stage.
//
// Owns the architectural HI/LO registers. Multiply and divide operations are
// captured on the accepting edge and complete after a fixed number of busy
// cycles. While an operation is in flight, md_stall tells the hazard unit to
// hold the pipeline. An exception request (req) cancels a start in the same
// cycle. It does not abort an operation that is already running.
//
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu
// (op codes 7-10). These accumulate into {hi,lo} with MULT_CYCLES latency.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   E-stage instruction is an MDU op this cycle
//   mdop[3:0] in   op code (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                  5 mthi, 6 mtlo, 7-10 madd/maddu/msub/msubu)
//   a[31:0]   in   rs operand
//   b[31:0]   in   rt operand
//   req       in   exception taken this cycle; suppresses start
//   busy      out  operation in flight (registered)
//   md_stall  out  busy, or a multi-cycle op being issued this cycle
//   hi[31:0]  out  HI register
//   lo[31:0]  out  LO register
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd10;

`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic       MADD_EN  = 1'b1;
`else
  localparam logic       MADD_EN  = 1'b0;
`endif

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_p0;
  logic [31:0]      a_p0;
  logic [31:0]      b_p0;
  logic [63:0]      result;
  logic             result_wr;

  function automatic logic is_multi(input logic [3:0] op);
    logic m;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: m = 1'b1;
      default: m = MADD_EN && (op >= OP_MADD) && (op <= OP_MSUBU);
    endcase
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] latency(input logic [3:0] op);
    if (op == OP_DIV || op == OP_DIVU)
      return CNT_W'(DIV_CYCLES);
    return CNT_W'(MULT_CYCLES);
  endfunction

  function automatic logic [63:0] mul_s(input logic signed [31:0] x,
                                        input logic signed [31:0] y);
    logic signed [63:0] xe;
    logic signed [63:0] ye;
    xe = x;
    ye = y;
    return xe * ye;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = {32'd0, x};
    ye = {32'd0, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}. The divide runs on magnitudes, so
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 without overflow.
  function automatic logic [63:0] div_s(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] ux;
    logic [31:0] uy;
    logic [31:0] q;
    logic [31:0] r;
    ux = x[31] ? -x : x;
    uy = y[31] ? -y : y;
    if (uy == 32'd0) uy = 32'd1;
    q = ux / uy;
    r = ux % uy;
    if (x[31] ^ y[31]) q = -q;
    if (x[31]) r = -r;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] yd;
    yd = (y == 32'd0) ? 32'd1 : y;
    return {x % yd, x / yd};
  endfunction

  // Completion result from the captured operands. A divide by zero
  // leaves HI/LO untouched.
  always_comb begin
    result    = {hi, lo};
    result_wr = 1'b1;
    case (op_p0)
      OP_MULT:  result = mul_s(a_p0, b_p0);
      OP_MULTU: result = mul_u(a_p0, b_p0);
      OP_DIV: begin
        result    = div_s(a_p0, b_p0);
        result_wr = (b_p0 != 32'd0);
      end
      OP_DIVU: begin
        result    = div_u(a_p0, b_p0);
        result_wr = (b_p0 != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi, lo} + mul_s(a_p0, b_p0);
      OP_MADDU: result = {hi, lo} + mul_u(a_p0, b_p0);
      OP_MSUB:  result = {hi, lo} - mul_s(a_p0, b_p0);
      OP_MSUBU: result = {hi, lo} - mul_u(a_p0, b_p0);
`endif
      default:  result_wr = 1'b0;
    endcase
  end

  // Issue stage: capture operands. Completion: counter reaches 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_p0 <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !req) begin
            if (is_multi(mdop)) begin
              op_p0 <= mdop;
              a_p0  <= a;
              b_p0  <= b;
              cnt   <= latency(mdop);
              state <= S_RUN;
            end else if (mdop == OP_MTHI) begin
              hi <= a;
            end else if (mdop == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        S_RUN: begin
          if (cnt == CNT_W'(1)) begin
            if (result_wr) begin
              hi <= result[63:32];
              lo <= result[31:0];
            end
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state == S_RUN);
  assign md_stall = busy | (start & is_multi(mdop) & ~req);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: reset sequences, a vector table,
// hand-written multi-cycle corner cases and randomized ops against a
// behavioural model.
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] cur_h = 32'd0;
  logic [31:0] cur_l = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .a(a), .b(b),
    .req(req), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    bit          rq;
    logic [31:0] eh;
    logic [31:0] el;
    int          ecyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural behaviour of one issued op: new HI/LO and busy length.
  task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit rq, inout logic [31:0] mh, inout logic [31:0] ml,
                       output int cyc);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     acc;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    acc = {mh, ml};
    cyc = 0;
    if (rq) return;
    case (op)
      4'd1: begin acc = sx * sy; cyc = MC; end
      4'd2: begin acc = ux * uy; cyc = MC; end
      4'd3: begin
        cyc = DC;
        if (y != 0) acc = {32'(sx % sy), 32'(sx / sy)};
      end
      4'd4: begin
        cyc = DC;
        if (y != 0) acc = {32'(ux % uy), 32'(ux / uy)};
      end
      4'd5: acc[63:32] = x;
      4'd6: acc[31:0]  = x;
      4'd7:  if (MADD) begin acc = acc + 64'(sx * sy); cyc = MC; end
      4'd8:  if (MADD) begin acc = acc + 64'(ux * uy); cyc = MC; end
      4'd9:  if (MADD) begin acc = acc - 64'(sx * sy); cyc = MC; end
      4'd10: if (MADD) begin acc = acc - 64'(ux * uy); cyc = MC; end
      default: ;
    endcase
    mh = acc[63:32];
    ml = acc[31:0];
  endtask

  // Issue one op, count busy cycles, check HI/LO hold during RUN and the
  // result in the first cycle busy is low. noisy drives junk inputs in RUN.
  task automatic apply(input string tag, input vec_t v, input bit noisy);
    int cyc;
    bit hold_ok;
    @(negedge clk);
    start = 1'b1; mdop = v.op; a = v.x; b = v.y; req = v.rq;
    #1;
    check({tag, " stall"}, {31'd0, md_stall}, {31'd0, v.ecyc > 0});
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0; a = $urandom; b = $urandom; mdop = 4'($urandom);
    hold_ok = 1'b1;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (hi !== cur_h || lo !== cur_l || md_stall !== 1'b1) hold_ok = 1'b0;
      if (noisy) begin
        start = 1'($urandom); mdop = 4'($urandom); req = 1'($urandom);
        a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; req = 1'b0;
    check({tag, " cycles"}, 32'(cyc), 32'(v.ecyc));
    check({tag, " hi"}, hi, v.eh);
    check({tag, " lo"}, lo, v.el);
    if (v.ecyc > 0) check({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
    cur_h = v.eh;
    cur_l = v.el;
  endtask

  initial begin
    vec_t tbl[14];
    vec_t v;
    int   cyc;
    logic [31:0] nh, nl;

    // ---------------- reset ----------------
    reset = 1'b1; start = 1'b0; mdop = 4'd0; a = '0; b = '0; req = 1'b0;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    check("reset stall", {31'd0, md_stall}, 32'd0);

    // ---------------- reset mid-mult ----------------
    v = '{op: 4'd5, x: 32'hAAAA5555, y: 32'd0, rq: 1'b0, eh: 32'hAAAA5555, el: 32'd0, ecyc: 0};
    apply("pre mthi", v, 1'b0);
    @(negedge clk); start = 1'b1; mdop = 4'd1; a = 32'd3; b = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    check("midrst busy before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midrst later busy", {31'd0, busy}, 32'd0);
    check("midrst later hi", hi, 32'd0);
    check("midrst later lo", lo, 32'd0);
    cur_h = 32'd0; cur_l = 32'd0;

    // ---------------- vector table ----------------
    tbl[0]  = '{4'd1,  32'hFFFFFFFF, 32'h2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
    tbl[1]  = '{4'd2,  32'hFFFFFFFF, 32'h2,        1'b0, 32'h00000001, 32'hFFFFFFFE, MC};
    tbl[2]  = '{4'd3,  32'hFFFFFFF9, 32'h2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[3]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, DC};
    tbl[4]  = '{4'd4,  32'h7,        32'h0,        1'b0, 32'h00000000, 32'h80000000, DC};
    tbl[5]  = '{4'd5,  32'h12345678, 32'h0,        1'b0, 32'h12345678, 32'h80000000, 0};
    tbl[6]  = '{4'd6,  32'hFFFFFFFF, 32'h0,        1'b0, 32'h12345678, 32'hFFFFFFFF, 0};
    tbl[7]  = '{4'd1,  32'h3,        32'h4,        1'b1, 32'h12345678, 32'hFFFFFFFF, 0};
    tbl[8]  = '{4'd0,  32'h3,        32'h4,        1'b0, 32'h12345678, 32'hFFFFFFFF, 0};
    tbl[9]  = '{4'd15, 32'h3,        32'h4,        1'b0, 32'h12345678, 32'hFFFFFFFF, 0};
    tbl[10] = '{4'd5,  32'h0,        32'h0,        1'b0, 32'h00000000, 32'hFFFFFFFF, 0};
`ifdef MDU_MADD_EN
    tbl[11] = '{4'd7,  32'h1,        32'h1,        1'b0, 32'h00000001, 32'h00000000, MC};
`else
    tbl[11] = '{4'd7,  32'h1,        32'h1,        1'b0, 32'h00000000, 32'hFFFFFFFF, 0};
`endif
    tbl[12] = '{4'd4,  32'd100,      32'd7,        1'b0, 32'h00000002, 32'h0000000E, DC};
    tbl[13] = '{4'd1,  32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, MC};
    for (int i = 0; i < 14; i++) apply($sformatf("vec%0d", i), tbl[i], 1'b0);

    // ---------------- start during RUN is ignored ----------------
    @(negedge clk); start = 1'b1; mdop = 4'd1; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    mdop = 4'd3; a = 32'd100; b = 32'd3;
    check("ignore stall", {31'd0, md_stall}, 32'd1);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      start = (cyc < 3);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ignore cycles", 32'(cyc), 32'(MC));
    check("ignore hi", hi, 32'd0);
    check("ignore lo", lo, 32'd30);
    @(posedge clk); #1;
    check("ignore no reissue", {31'd0, busy}, 32'd0);

    // ---------------- req during RUN does not abort ----------------
    @(negedge clk); start = 1'b1; mdop = 4'd3; a = 32'd100; b = 32'hFFFFFFF9;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      req = (cyc >= 2 && cyc <= 4);
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    req = 1'b0;
    check("reqrun cycles", 32'(cyc), 32'(DC));
    check("reqrun hi", hi, 32'h00000002);
    check("reqrun lo", lo, 32'hFFFFFFF2);
    cur_h = 32'h00000002; cur_l = 32'hFFFFFFF2;

    // ---------------- randomized against model ----------------
    for (int i = 0; i < 150; i++) begin
      v.op = 4'($urandom_range(0, 15));
      v.x  = ($urandom % 6 == 0) ? 32'h80000000 : $urandom;
      if ($urandom % 5 == 0)      v.y = 32'd0;
      else if ($urandom % 3 == 0) v.y = 32'($urandom_range(1, 15)) ^ {32{1'($urandom)}};
      else                        v.y = $urandom;
      v.rq = ($urandom % 8 == 0);
      nh = cur_h; nl = cur_l;
      model(v.op, v.x, v.y, v.rq, nh, nl, cyc);
      v.eh = nh; v.el = nl; v.ecyc = cyc;
      apply($sformatf("rnd%0d op%0d", i, v.op), v, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
